// File: rtl/rr_grant_sched_4.sv
// ---------------------------------------------------------------------------
// rr_grant_sched_4
//
// Round-robin scheduler that shares one resource among four requesters.
// The owner index is held in a register, and the one-hot grant is the
// registered 2-to-4 decode of that index. A rotating priority pointer keeps
// the scheme fair. A hold counter limits how long one owner may keep the
// grant while other requesters are waiting.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles while others wait (0 = no limit)
//   HOLD_W    hold counter width, 2**HOLD_W >= MAX_HOLD
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req[3:0]   level-sensitive request, bit n = requester n
//   gnt[3:0]   one-hot grant, all zero while no grant is active
//   gnt_idx    registered index of the current (or last) owner
//   gnt_valid  high while a grant is active
// ---------------------------------------------------------------------------
module rr_grant_sched_4 #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   // With no hold limit, the counter just saturates at its all-ones value
   // and never triggers a rotation.
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        ptr;
   logic [1:0]        ptr_nxt;
   logic [1:0]        idx_nxt;
   logic              valid_nxt;
   logic [3:0]        gnt_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   logic [1:0]        after_owner;
   logic [3:0]        others;
   logic              expiring;

   // Return the first set bit of r, searching upward from start and
   // wrapping modulo 4.
   function automatic logic [1:0] pick_first(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] cand;
      logic [1:0] res;
      logic       found;
      res   = start;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cand = start + 2'(i);
         if (r[cand] && !found) begin
            res   = cand;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Helper terms about the current owner. "others" is the set of waiting
   // requesters excluding the owner. "expiring" marks that the owner has
   // used its whole hold window.
   always_comb begin
      after_owner = gnt_idx + 2'd1;
      others      = req & ~(4'b0001 << gnt_idx);
      expiring    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
   end

   // Next-state and next-output logic. All registered outputs are computed
   // here, so that gnt and gnt_valid never depend combinationally on req.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = gnt_idx;
      valid_nxt = gnt_valid;
      hold_nxt  = hold_cnt;
      unique case (state)
         IDLE: begin
            valid_nxt = 1'b0;
            if (req != 4'b0000) begin
               state_nxt = GRANT;
               idx_nxt   = pick_first(req, ptr);
               valid_nxt = 1'b1;
               hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (!req[gnt_idx]) begin
               // Release: hand over directly, or fall back to IDLE while
               // keeping the last owner index.
               ptr_nxt  = after_owner;
               hold_nxt = '0;
               if (req != 4'b0000) begin
                  idx_nxt = pick_first(req, after_owner);
               end else begin
                  state_nxt = IDLE;
                  valid_nxt = 1'b0;
               end
            end else if (expiring && (others != 4'b0000)) begin
               // Forced rotation. The owner is masked out, so it cannot
               // win again immediately.
               ptr_nxt  = after_owner;
               idx_nxt  = pick_first(others, after_owner);
               hold_nxt = '0;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase
      gnt_nxt = valid_nxt ? (4'b0001 << idx_nxt) : 4'b0000;
   end

   // State and output registers. Reset clears everything immediately,
   // even in the middle of a grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         gnt_idx   <= 2'd0;
         gnt_valid <= 1'b0;
         gnt       <= 4'b0000;
         hold_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         gnt_idx   <= idx_nxt;
         gnt_valid <= valid_nxt;
         gnt       <= gnt_nxt;
         hold_cnt  <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_rr_grant_sched_4.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_sched_4
//
// Directed scenarios followed by randomized request traffic for
// rr_grant_sched_4. A behavioural reference model tracks the owner, the
// rotation pointer and how many cycles the owner has held the grant.
// ---------------------------------------------------------------------------
module tb_rr_grant_sched_4;

   localparam int MAX_HOLD = 8;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;

   int errors;
   int checks;

   // Reference model state
   bit m_valid;
   int m_idx;
   int m_ptr;
   int m_held;

   rr_grant_sched_4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // Free-running clock with a 10-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // First requester set in r, looking from start upward modulo 4
   function automatic int firstFrom(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return 0;
   endfunction

   // Reset value of the model
   task automatic modelReset();
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      m_held  = 0;
   endtask

   // One clock of the scheduling rules, with r as the request seen at the edge
   task automatic modelStep(input logic [3:0] r);
      logic [3:0] rest;
      if (!m_valid) begin
         if (r != 4'b0000) begin
            m_idx   = firstFrom(r, m_ptr);
            m_valid = 1'b1;
            m_held  = 1;
         end
      end else if (!r[m_idx]) begin
         m_ptr = (m_idx + 1) % 4;
         if (r != 4'b0000) begin
            m_idx  = firstFrom(r, m_ptr);
            m_held = 1;
         end else begin
            m_valid = 1'b0;
         end
      end else begin
         rest = r;
         rest[m_idx] = 1'b0;
         if (m_held >= MAX_HOLD && rest != 4'b0000) begin
            m_ptr  = (m_idx + 1) % 4;
            m_idx  = firstFrom(rest, m_ptr);
            m_held = 1;
         end else begin
            m_held = m_held + 1;
         end
      end
   endtask

   // Drive a request value, let one edge pass, advance the model, then
   // settle to a sampling point just after the edge.
   task automatic applyStimulus(input logic [3:0] r);
      req = r;
      @(posedge clk);
      modelStep(r);
      #1;
   endtask

   // Compare all outputs against the model
   task automatic checkOutput(input string tag);
      logic [3:0] expGnt;
      expGnt = m_valid ? 4'(1 << m_idx) : 4'b0000;
      checks++;
      assert (gnt === expGnt) else begin
         errors++;
         $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, gnt, expGnt);
      end
      checks++;
      assert (gnt_valid === m_valid) else begin
         errors++;
         $error("[TB] FAIL %s gnt_valid observed=%b expected=%b", tag, gnt_valid, m_valid);
      end
      checks++;
      assert (gnt_idx === 2'(m_idx)) else begin
         errors++;
         $error("[TB] FAIL %s gnt_idx observed=%0d expected=%0d", tag, gnt_idx, m_idx);
      end
   endtask

   // Pulse reset between clock edges and check that the outputs clear at once
   task automatic doReset(input logic [3:0] r);
      #1;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput("async_reset");
      req = r;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] cur;
      errors = 0;
      checks = 0;
      modelReset();

      // 1. Reset holds the outputs at zero even with every request high
      rst = 1'b1;
      req = 4'b1111;
      #3;
      checkOutput("reset_req_all");
      @(posedge clk);
      #1;
      checkOutput("reset_held_edge");
      req = 4'b0000;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0000);
         checkOutput("idle_no_req");
      end

      // 2. Grant with one cycle of latency, then a handover with no gap
      applyStimulus(4'b0101);
      checkOutput("first_grant");
      checks++;
      assert (gnt === 4'b0001) else begin
         errors++;
         $error("[TB] FAIL first_grant_const gnt observed=%b expected=0001", gnt);
      end
      applyStimulus(4'b0100);
      checkOutput("handover");
      checks++;
      assert (gnt === 4'b0100) else begin
         errors++;
         $error("[TB] FAIL handover_const gnt observed=%b expected=0100", gnt);
      end

      // 3. All requests held: each owner keeps the grant for 8 cycles, in rotation
      doReset(4'b1111);
      for (int k = 0; k < 40; k++) begin
         applyStimulus(4'b1111);
         checkOutput("rotate_all");
         checks++;
         assert (gnt_valid === 1'b1 && gnt_idx === 2'((k / 8) % 4)) else begin
            errors++;
            $error("[TB] FAIL rotate_seq cycle=%0d idx observed=%0d expected=%0d", k, gnt_idx, (k / 8) % 4);
         end
      end

      // 4. A lone requester keeps the grant, then yields when another arrives
      doReset(4'b1000);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(4'b1000);
         checkOutput("lone_req3");
         checks++;
         assert (gnt === 4'b1000) else begin
            errors++;
            $error("[TB] FAIL lone_const cycle=%0d gnt observed=%b expected=1000", k, gnt);
         end
      end
      applyStimulus(4'b1010);
      checkOutput("lone_yield");
      checks++;
      assert (gnt === 4'b0010) else begin
         errors++;
         $error("[TB] FAIL lone_yield_const gnt observed=%b expected=0010", gnt);
      end

      // 5. Pointer wraps from 3 back to 0, then the scheduler goes idle
      applyStimulus(4'b1000);
      checkOutput("to_owner3");
      applyStimulus(4'b0011);
      checkOutput("wrap");
      checks++;
      assert (gnt === 4'b0001) else begin
         errors++;
         $error("[TB] FAIL wrap_const gnt observed=%b expected=0001", gnt);
      end
      applyStimulus(4'b0000);
      checkOutput("go_idle");

      // 6. Reset in the middle of a grant clears the outputs before the next edge
      applyStimulus(4'b0100);
      checkOutput("owner2");
      doReset(4'b1010);
      checks++;
      assert (gnt === 4'b0000 && gnt_valid === 1'b0) else begin
         errors++;
         $error("[TB] FAIL mid_reset gnt observed=%b valid=%b expected=0000/0", gnt, gnt_valid);
      end
      applyStimulus(4'b1010);
      checkOutput("after_reset");

      // Random traffic: requests persist for a while and owners drop at random
      cur = 4'b0000;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
         if (m_valid && $urandom_range(0, 11) == 0) cur[m_idx] = 1'b0;
         if ($urandom_range(0, 149) == 0) doReset(cur);
         applyStimulus(cur);
         checkOutput("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
